ser_frame_scheduler: RTL and testbench
======================================

// Module: ser_frame_scheduler
// PURPOSE
//  Round-robin frame scheduler that sits between NUM_REQ byte-stream requesters and one OSER8 serializer lane.
//  Grants one requester per frame, then builds the frame: preamble, SFD, payload, optional checksum, inter-frame gap.
//  Manchester-encodes each byte into two 8-bit words, one word per pclk strobe, for OSER8 D0..D7 (D0 sent first).
// PARAMETERS
//  NUM_REQ       2      number of requesters (2..4)
//  PREAMBLE_LEN  2      preamble bytes of 8'hAA before SFD (1..7)
//  SFD_BYTE      8'hD5  start-of-frame delimiter byte
//  IFG_WORDS     12     idle words forced after every frame or abort (>=1)
//  IDLE_WORD     8'h00  ser_word value whenever ser_tx_en=0
// PORTS
//  clk108     in   1          fast clock; all logic on posedge
//  reset      in   1          synchronous, active-high
//  ce         in   1          1-in-4 pclk strobe; state advances only when ce=1
//  req_valid  in   NUM_REQ    per-requester byte valid
//  req_data   in   8*NUM_REQ  per-requester byte, requester k at [8k+7:8k]
//  req_last   in   NUM_REQ    marks final payload byte of the frame
//  req_ready  out  NUM_REQ    byte accepted this cycle (combinational, one-hot or zero)
//  ser_word   out  8          registered word to OSER8 D[7:0]
//  ser_tx_en  out  1          registered; 1 while a frame word is on ser_word
//  grant_id   out  2          registered index of the current/last granted requester
//  busy       out  1          state != IDLE
//  frame_done out  1          1-cycle pulse on the ce where a frame completes normally
//  underrun   out  1          1-cycle pulse on the ce where a frame aborts
// BEHAVIOUR
//  Reset: state=IDLE, ser_word=IDLE_WORD, ser_tx_en=0, grant_id=0, rr pointer=0, pulses 0; applies mid-frame and drops tx at once.
//  Encoding: man[2i]=d[i], man[2i+1]=~d[i]. First half word=man[7:0], second=man[15:8]. A half flag toggles on every ce in a frame state.
//  States: IDLE -> PRE -> SFD -> PAY -> [CSUM] -> IFG -> IDLE.
//  IDLE: on ce with any req_valid, grant the first valid requester at or after rr pointer.
//    Set rr pointer = grant+1 mod NUM_REQ and enter PRE. The same edge outputs the first preamble word.
//  PRE: 2*PREAMBLE_LEN words (0x66 each for 8'hAA). SFD: 2 words (0x99, 0x59 for 8'hD5).
//  Fetch: req_ready[g] = ce & half==1 & (state==SFD | (state==PAY & !last_q)). Byte and last flag register on that edge.
//  PAY: 2 words per byte. After the second half of a byte with last_q=1, go to CSUM (if enabled) or IFG, and pulse frame_done.
//  Underrun: at a fetch point with req_valid[g]=0:
//    underrun pulse, ser_tx_en=0 and ser_word=IDLE_WORD from that edge, go to IFG.
//    The requester stays granted for nothing further.
//  IFG: IFG_WORDS ce strobes, tx_en=0; then IDLE. New requests are ignored until IDLE.
//  Latency: grant ce to first word = 0 ce; between bytes = 0 gap (continuous stream).
//  ce=0: all registers hold; req_ready=0.
//  Non-granted req_ready stays 0 throughout. req_data/last change on non-granted inputs has no effect.
// CONFIGURATION
//  SER_SEQ_CHECKSUM_EN defined:
//    XOR of all payload bytes is sent as one extra byte (2 words) in CSUM after the last byte.
//    frame_done pulses at end of CSUM.
//  Not defined: no CSUM state; PAY goes directly to IFG.
// STRUCTURE
//  Shared header ser_seq_defs.vh: state encodings, PREAMBLE_BYTE 8'hAA, man_lo/man_hi helper functions.
//  One sub-module: manchester_encoder (8 -> 16 bit, combinational), fed by the muxed byte (preamble/SFD/payload/checksum).
//  Round-robin arbiter and frame FSM stay inline.
// TESTING
//  1. Reset, req0 sends 1 byte 8'hAA (last=1), ce every 4 clk -> ser_word 66,66,66,66,99,59,66,66 with tx_en=1;
//     frame_done on 8th ce; then 12 idle ce.
//  2. req0 and req1 valid simultaneously from reset -> req0 framed first, then req1 after IFG; grant_id 0 then 1.
//  3. req0 3-byte frame 01,02,03: req_ready pulses exactly 3 times, on SFD half 1 and PAY half 1 ce's.
//     With SER_SEQ_CHECKSUM_EN, the frame carries a checksum byte 8'h00.
//  4. Drop req_valid before the 2nd payload byte -> underrun pulse, tx_en low on that ce, IFG, no frame_done.
//  5. Assert reset mid-payload -> next cycle ser_word=00, tx_en=0, busy=0, req_ready=0.
//  6. ce held low 20 cycles mid-frame -> all outputs frozen; stream resumes unchanged.

Source files
------------

// File: rtl/ser_frame_scheduler_pkg.sv
// Shared state encodings and Manchester helpers for ser_frame_scheduler.
// SER_SEQ_CHECKSUM_EN adds the CSUM state to the encoding.
package ser_frame_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_SFD  = 3'd2,
      ST_PAY  = 3'd3,
`ifdef SER_SEQ_CHECKSUM_EN
      ST_CSUM = 3'd4,
`endif
      ST_IFG  = 3'd5
   } state_e;

   localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;

   // Low nibble of the byte expands to the first word on the wire.
   function automatic logic [7:0] man_lo(input logic [7:0] d);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[2*i]   = d[i];
         m[2*i+1] = ~d[i];
      end
      return m;
   endfunction

   function automatic logic [7:0] man_hi(input logic [7:0] d);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[2*i]   = d[i+4];
         m[2*i+1] = ~d[i+4];
      end
      return m;
   endfunction

endpackage

// File: rtl/manchester_encoder.sv
// Combinational 8 -> 16 bit Manchester expansion; bit 2i carries d[i], bit 2i+1 its complement.
module manchester_encoder
   import ser_frame_scheduler_pkg::*;
(
   input  logic [7:0]  data_i,
   output logic [15:0] man_o
);

   assign man_o = {man_hi(data_i), man_lo(data_i)};

endmodule

// File: rtl/ser_frame_scheduler.sv
// Round-robin frame scheduler feeding one OSER8 lane with Manchester words.
// Optional checksum byte after the payload when SER_SEQ_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | no frame; grants on the first ce with any req_valid
// PRE   | preamble bytes (0xAA), two words each
// SFD   | start-of-frame delimiter; second half fetches the first payload byte
// PAY   | payload bytes; second half fetches the next byte unless last_q
// CSUM  | XOR checksum byte (checksum builds only)
// IFG   | forced idle words, requests ignored
module ser_frame_scheduler
   import ser_frame_scheduler_pkg::*;
#(
   parameter int         NUM_REQ      = 2,
   parameter int         PREAMBLE_LEN = 2,
   parameter logic [7:0] SFD_BYTE     = 8'hD5,
   parameter int         IFG_WORDS    = 12,
   parameter logic [7:0] IDLE_WORD    = 8'h00
)(
   input  logic                 clk108,
   input  logic                 reset,
   input  logic                 ce,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           ser_word,
   output logic                 ser_tx_en,
   output logic [1:0]           grant_id,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 underrun
);

   localparam int IFG_W = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
   localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_WORDS - 1);

   state_e           state_q, state_d;
   logic             half_q, half_d;
   logic [2:0]       pre_cnt_q, pre_cnt_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       rr_q, rr_d;
   logic [7:0]       byte_q, byte_d;
   logic             last_q, last_d;
   logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
   logic [7:0]       word_q, word_d;
   logic             tx_en_q, tx_en_d;
   logic             frame_done_q, frame_done_d;
   logic             underrun_q, underrun_d;
`ifdef SER_SEQ_CHECKSUM_EN
   logic [7:0]       csum_q, csum_d;
`endif

   logic [3:0]  valid_ext, last_ext;
   logic [7:0]  data_arr [4];
   logic [1:0]  grant_sel, rr_next;
   logic [2:0]  cand;
   logic        fetch;
   logic [7:0]  enc_byte;
   logic [15:0] man_w;
   logic [7:0]  enc_word;

   // Pad requester inputs to four slots so 2-bit indices always fit.
   always_comb begin
      valid_ext = '0;
      last_ext  = '0;
      for (int k = 0; k < 4; k++) data_arr[k] = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         valid_ext[k] = req_valid[k];
         last_ext[k]  = req_last[k];
         data_arr[k]  = req_data[8*k +: 8];
      end
   end

   // Scan downwards so the closest valid requester at or after rr_q wins.
   always_comb begin
      grant_sel = rr_q;
      cand      = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = {1'b0, rr_q} + 3'(off);
         if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
         if (valid_ext[cand[1:0]]) grant_sel = cand[1:0];
      end
      rr_next = (grant_sel == 2'(NUM_REQ - 1)) ? 2'd0 : grant_sel + 2'd1;
   end

   always_comb begin
      enc_byte = PREAMBLE_BYTE;
      case (state_q)
         ST_SFD:  enc_byte = SFD_BYTE;
         ST_PAY:  enc_byte = byte_q;
`ifdef SER_SEQ_CHECKSUM_EN
         ST_CSUM: enc_byte = csum_q;
`endif
         default: enc_byte = PREAMBLE_BYTE;
      endcase
   end

   manchester_encoder u_enc (
      .data_i (enc_byte),
      .man_o  (man_w)
   );

   assign enc_word = half_q ? man_w[15:8] : man_w[7:0];

   always_comb begin
      state_d      = state_q;
      half_d       = half_q;
      pre_cnt_d    = pre_cnt_q;
      grant_d      = grant_q;
      rr_d         = rr_q;
      byte_d       = byte_q;
      last_d       = last_q;
      ifg_cnt_d    = ifg_cnt_q;
      word_d       = word_q;
      tx_en_d      = tx_en_q;
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;
`ifdef SER_SEQ_CHECKSUM_EN
      csum_d       = csum_q;
`endif
      fetch        = 1'b0;
      req_ready    = '0;
      if (ce) begin
         case (state_q)
            ST_IDLE: begin
               if (|req_valid) begin
                  state_d   = ST_PRE;
                  half_d    = 1'b1;
                  pre_cnt_d = '0;
                  grant_d   = grant_sel;
                  rr_d      = rr_next;
                  word_d    = enc_word;
                  tx_en_d   = 1'b1;
`ifdef SER_SEQ_CHECKSUM_EN
                  csum_d    = '0;
`endif
               end
            end
            ST_PRE: begin
               word_d = enc_word;
               half_d = ~half_q;
               if (half_q) begin
                  if (pre_cnt_q == 3'(PREAMBLE_LEN - 1)) state_d = ST_SFD;
                  else pre_cnt_d = pre_cnt_q + 3'd1;
               end
            end
            ST_SFD: begin
               word_d = enc_word;
               half_d = ~half_q;
               if (half_q) begin
                  fetch   = 1'b1;
                  state_d = ST_PAY;
               end
            end
            ST_PAY: begin
               word_d = enc_word;
               half_d = ~half_q;
               if (half_q) begin
                  if (last_q) begin
`ifdef SER_SEQ_CHECKSUM_EN
                     state_d      = ST_CSUM;
`else
                     state_d      = ST_IFG;
                     ifg_cnt_d    = IFG_LOAD;
                     frame_done_d = 1'b1;
`endif
                  end else begin
                     fetch = 1'b1;
                  end
               end
            end
`ifdef SER_SEQ_CHECKSUM_EN
            ST_CSUM: begin
               word_d = enc_word;
               half_d = ~half_q;
               if (half_q) begin
                  state_d      = ST_IFG;
                  ifg_cnt_d    = IFG_LOAD;
                  frame_done_d = 1'b1;
               end
            end
`endif
            ST_IFG: begin
               word_d  = IDLE_WORD;
               tx_en_d = 1'b0;
               half_d  = 1'b0;
               if (ifg_cnt_q == '0) state_d = ST_IDLE;
               else ifg_cnt_d = ifg_cnt_q - IFG_W'(1);
            end
            default: state_d = ST_IDLE;
         endcase

         // A missing byte at a fetch point aborts the frame on this same edge.
         if (fetch) begin
            for (int k = 0; k < NUM_REQ; k++) req_ready[k] = (grant_q == 2'(k));
            if (valid_ext[grant_q]) begin
               byte_d = data_arr[grant_q];
               last_d = last_ext[grant_q];
`ifdef SER_SEQ_CHECKSUM_EN
               csum_d = csum_q ^ data_arr[grant_q];
`endif
            end else begin
               underrun_d = 1'b1;
               word_d     = IDLE_WORD;
               tx_en_d    = 1'b0;
               half_d     = 1'b0;
               state_d    = ST_IFG;
               ifg_cnt_d  = IFG_LOAD;
            end
         end
      end
   end

   always_ff @(posedge clk108) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         half_q       <= 1'b0;
         pre_cnt_q    <= '0;
         grant_q      <= '0;
         rr_q         <= '0;
         byte_q       <= '0;
         last_q       <= 1'b0;
         ifg_cnt_q    <= '0;
         word_q       <= IDLE_WORD;
         tx_en_q      <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
`ifdef SER_SEQ_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         half_q       <= half_d;
         pre_cnt_q    <= pre_cnt_d;
         grant_q      <= grant_d;
         rr_q         <= rr_d;
         byte_q       <= byte_d;
         last_q       <= last_d;
         ifg_cnt_q    <= ifg_cnt_d;
         word_q       <= word_d;
         tx_en_q      <= tx_en_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
`ifdef SER_SEQ_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign ser_word   = word_q;
   assign ser_tx_en  = tx_en_q;
   assign grant_id   = grant_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_ser_frame_scheduler.sv
// Scoreboard bench for ser_frame_scheduler; expected words are queued when frames are offered.
module tb_ser_frame_scheduler;

   localparam int NUM_REQ = 2;
   localparam int PL      = 2;
   localparam int IFGW    = 12;
`ifdef SER_SEQ_CHECKSUM_EN
   localparam int CS_WORDS = 2;
`else
   localparam int CS_WORDS = 0;
`endif

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } src_t;

   logic                 clk108 = 1'b0;
   logic                 reset;
   logic                 ce;
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           ser_word;
   logic                 ser_tx_en;
   logic [1:0]           grant_id;
   logic                 busy;
   logic                 frame_done;
   logic                 underrun;

   int         n_tests, n_fail;
   logic [7:0] exp_q[$];
   src_t       src0_q[$];
   src_t       src1_q[$];
   int         rdy_ce_q[$];
   int         ce_idx, fd_cnt, ud_cnt, fd_ce, ud_ce, rdy_cnt0, rdy_cnt1;
   logic [NUM_REQ-1:0] ready_snap;
   logic [7:0] csum_acc;
   logic [7:0] got_w;

   ser_frame_scheduler #(
      .NUM_REQ      (NUM_REQ),
      .PREAMBLE_LEN (PL),
      .SFD_BYTE     (8'hD5),
      .IFG_WORDS    (IFGW),
      .IDLE_WORD    (8'h00)
   ) dut (
      .clk108     (clk108),
      .reset      (reset),
      .ce         (ce),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .ser_word   (ser_word),
      .ser_tx_en  (ser_tx_en),
      .grant_id   (grant_id),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   always #5 clk108 = ~clk108;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic [7:0] d, input bit hi);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         m[2*i]   = d[i];
         m[2*i+1] = ~d[i];
      end
      return hi ? m[15:8] : m[7:0];
   endfunction

   task automatic push_hdr();
      for (int i = 0; i < 2*PL; i++) exp_q.push_back(8'h66);
      exp_q.push_back(8'h99);
      exp_q.push_back(8'h59);
      csum_acc = 8'h00;
   endtask

   task automatic push_byte(input logic [7:0] b);
      exp_q.push_back(enc(b, 1'b0));
      exp_q.push_back(enc(b, 1'b1));
      csum_acc = csum_acc ^ b;
   endtask

   task automatic push_csum();
      if (CS_WORDS > 0) begin
         exp_q.push_back(enc(csum_acc, 1'b0));
         exp_q.push_back(enc(csum_acc, 1'b1));
      end
   endtask

   task automatic src_add(input int k, input logic [7:0] d, input logic l);
      src_t s;
      s.d = d;
      s.l = l;
      if (k == 0) src0_q.push_back(s);
      else src1_q.push_back(s);
   endtask

   task automatic drive_sources();
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      if (src0_q.size() > 0) begin
         req_valid[0]   = 1'b1;
         req_data[7:0]  = src0_q[0].d;
         req_last[0]    = src0_q[0].l;
      end
      if (src1_q.size() > 0) begin
         req_valid[1]   = 1'b1;
         req_data[15:8] = src1_q[0].d;
         req_last[1]    = src1_q[0].l;
      end
   endtask

   task automatic post_ce();
      ce_idx++;
      if (ready_snap[0]) begin
         rdy_cnt0++;
         rdy_ce_q.push_back(ce_idx);
         if (req_valid[0]) void'(src0_q.pop_front());
      end
      if (ready_snap[1]) begin
         rdy_cnt1++;
         if (req_valid[1]) void'(src1_q.pop_front());
      end
      if (frame_done) begin
         fd_cnt++;
         fd_ce = ce_idx;
      end
      if (underrun) begin
         ud_cnt++;
         ud_ce = ce_idx;
      end
      if (ser_tx_en) begin
         check("exp_avail", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            got_w = exp_q.pop_front();
            check("word", ser_word, got_w);
         end
      end else begin
         check("idle_word", ser_word, 8'h00);
      end
   endtask

   task automatic clk_cycle(input logic ce_v);
      @(negedge clk108);
      ce = ce_v;
      drive_sources();
      #1;
      ready_snap = req_ready;
      @(posedge clk108);
      #1;
      if (ce_v) post_ce();
   endtask

   task automatic run_ce(input int n);
      repeat (n) begin
         clk_cycle(1'b0);
         clk_cycle(1'b0);
         clk_cycle(1'b0);
         clk_cycle(1'b1);
      end
   endtask

   task automatic do_reset();
      src0_q.delete();
      src1_q.delete();
      exp_q.delete();
      rdy_ce_q.delete();
      reset = 1'b1;
      repeat (2) clk_cycle(1'b0);
      reset = 1'b0;
      ce_idx = 0; fd_cnt = 0; ud_cnt = 0; fd_ce = 0; ud_ce = 0;
      rdy_cnt0 = 0; rdy_cnt1 = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fl1, fl3, fl6;
      n_tests = 0; n_fail = 0;
      reset = 1'b1; ce = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0;
      fl1 = 2*PL + 2 + 2 + CS_WORDS;
      fl3 = 2*PL + 2 + 6 + CS_WORDS;
      fl6 = 2*PL + 2 + 4 + CS_WORDS;

      // single 0xAA byte frame
      do_reset();
      check("rst_word", ser_word, 8'h00);
      check("rst_tx", ser_tx_en, 1'b0);
      check("rst_gnt", grant_id, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", req_ready, 2'b00);
      check("rst_fd", frame_done, 1'b0);
      src_add(0, 8'hAA, 1'b1);
      push_hdr(); push_byte(8'hAA); push_csum();
      run_ce(fl1 + IFGW - 1);
      check("t1_busy_ifg", busy, 1'b1);
      run_ce(1);
      check("t1_busy_end", busy, 1'b0);
      run_ce(2);
      check("t1_fd_cnt", fd_cnt, 1);
      check("t1_fd_ce", fd_ce, fl1);
      check("t1_drain", exp_q.size(), 0);

      // two requesters, round robin
      do_reset();
      src_add(0, 8'h3C, 1'b1);
      src_add(1, 8'hC3, 1'b1);
      push_hdr(); push_byte(8'h3C); push_csum();
      push_hdr(); push_byte(8'hC3); push_csum();
      run_ce(1);
      check("t2_gnt0", grant_id, 2'd0);
      run_ce(fl1 + IFGW);
      check("t2_gnt1", grant_id, 2'd1);
      run_ce(fl1 + IFGW + 1);
      check("t2_fd_cnt", fd_cnt, 2);
      check("t2_rdy0", rdy_cnt0, 1);
      check("t2_rdy1", rdy_cnt1, 1);
      check("t2_drain", exp_q.size(), 0);

      // three-byte frame, ready timing
      do_reset();
      src_add(0, 8'h01, 1'b0);
      src_add(0, 8'h02, 1'b0);
      src_add(0, 8'h03, 1'b1);
      push_hdr(); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_csum();
      run_ce(fl3 + IFGW + 1);
      check("t3_rdy_n", rdy_cnt0, 3);
      for (int i = 0; i < 3 && i < rdy_ce_q.size(); i++)
         check("t3_rdy_ce", rdy_ce_q[i], 2*PL + 2 + 2*i);
      check("t3_fd_cnt", fd_cnt, 1);
      check("t3_fd_ce", fd_ce, fl3);
      check("t3_drain", exp_q.size(), 0);

      // underrun before the second payload byte
      do_reset();
      src_add(0, 8'h11, 1'b0);
      push_hdr();
      exp_q.push_back(enc(8'h11, 1'b0));
      run_ce(2*PL + 4);
      check("t4_ud_cnt", ud_cnt, 1);
      check("t4_ud_ce", ud_ce, 2*PL + 4);
      check("t4_tx", ser_tx_en, 1'b0);
      run_ce(IFGW - 1);
      check("t4_busy_ifg", busy, 1'b1);
      run_ce(1);
      check("t4_busy_end", busy, 1'b0);
      check("t4_fd_cnt", fd_cnt, 0);
      check("t4_drain", exp_q.size(), 0);

      // reset mid-payload
      do_reset();
      src_add(0, 8'hA1, 1'b0);
      src_add(0, 8'hA2, 1'b0);
      src_add(0, 8'hA3, 1'b0);
      src_add(0, 8'hA4, 1'b0);
      src_add(0, 8'hA5, 1'b1);
      push_hdr();
      push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4); push_byte(8'hA5);
      push_csum();
      run_ce(9);
      check("t5_busy_pre", busy, 1'b1);
      check("t5_tx_pre", ser_tx_en, 1'b1);
      @(negedge clk108);
      reset = 1'b1;
      ce    = 1'b1;
      drive_sources();
      @(posedge clk108);
      #1;
      check("t5_word", ser_word, 8'h00);
      check("t5_tx", ser_tx_en, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_ready", req_ready, 2'b00);
      @(negedge clk108);
      ce    = 1'b0;
      reset = 1'b0;

      // ce held low mid-frame
      do_reset();
      src_add(0, 8'h5A, 1'b0);
      src_add(0, 8'hA5, 1'b1);
      push_hdr(); push_byte(8'h5A); push_byte(8'hA5); push_csum();
      run_ce(7);
      for (int i = 0; i < 20; i++) begin
         clk_cycle(1'b0);
         check("t6_frz_word", ser_word, enc(8'h5A, 1'b0));
         check("t6_frz_tx", ser_tx_en, 1'b1);
      end
      check("t6_frz_busy", busy, 1'b1);
      check("t6_frz_fd", fd_cnt, 0);
      run_ce(fl6 - 7 + IFGW + 1);
      check("t6_fd_cnt", fd_cnt, 1);
      check("t6_fd_ce", fd_ce, fl6);
      check("t6_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
